// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-input registered stream mux with fixed-select or round-robin arbitration.
module rr_stream_mux #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan,
    output logic               out_valid,
    input  logic               out_ready
);
    logic [SELW-1:0] ptr, gidx;
    logic [N-1:0]    gnt;
    logic            hit, load, xfer;
    assign load = !out_valid || out_ready;
    always_comb begin
        hit  = 1'b0;
        gidx = '0;
        if (!mode) begin
            for (int i = 0; i < N; i++)
                if (int'(sel) == i && in_valid[i]) begin
                    hit  = 1'b1;
                    gidx = SELW'(i);
                end
        end else begin
            // scan farthest-to-nearest so the channel closest after ptr wins
            for (int k = N; k >= 1; k--)
                if (in_valid[(int'(ptr) + k) % N]) begin
                    hit  = 1'b1;
                    gidx = SELW'((int'(ptr) + k) % N);
                end
        end
        gnt = hit ? (N'(1) << gidx) : '0;
    end
    assign xfer     = hit && load;
    assign in_ready = rst_n ? (gnt & {N{load}}) : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= SELW'(N - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[gidx*WIDTH +: WIDTH];
            out_chan  <= gidx;
            if (mode) ptr <= gidx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed and randomized checks of rr_stream_mux against a behavioural model.
module tb_rr_stream_mux;
    logic        clk = 0;
    logic        rst_n = 1;
    logic        mode, out_ready, out_valid;
    logic [1:0]  sel, out_chan;
    logic [63:0] in_data;
    logic [3:0]  in_valid, in_ready;
    logic [15:0] out_data;

    logic        mode3, out_ready3, out_valid3;
    logic [1:0]  sel3, out_chan3;
    logic [47:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic [15:0] out_data3;

    int checks = 0, failures = 0;
    logic [15:0] w [4] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};

    always #5 clk = ~clk;

    rr_stream_mux #(.WIDTH(16), .N(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready));

    rr_stream_mux #(.WIDTH(16), .N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .in_data(in_data3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_chan(out_chan3), .out_valid(out_valid3), .out_ready(out_ready3));

    // Reference: the granted channel as an integer, -1 for none
    function automatic int exp_grant(input logic m, input int s, input logic [15:0] v,
                                     input int last, input int n);
        if (!m) return (s < n && v[s]) ? s : -1;
        for (int k = 1; k <= n; k++)
            if (v[(last + k) % n]) return (last + k) % n;
        return -1;
    endfunction

    logic        m_valid;
    logic [15:0] m_data;
    logic [1:0]  m_chan;
    int          m_last, m_g;
    logic [3:0]  m_rdy;
    assign m_g   = exp_grant(mode, int'(sel), {12'b0, in_valid}, m_last, 4);
    assign m_rdy = (rst_n && m_g >= 0 && (!m_valid || out_ready)) ? 4'(1 << m_g) : 4'b0;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m_valid <= 0; m_data <= 0; m_chan <= 0; m_last <= 3;
        end else if (m_g >= 0 && (!m_valid || out_ready)) begin
            m_valid <= 1; m_data <= in_data[m_g*16 +: 16]; m_chan <= 2'(m_g);
            if (mode) m_last <= m_g;
        end else if (out_ready) m_valid <= 0;

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        rst_n = 0; #2; rst_n = 1;
    endtask

    task automatic test_reset;
        mode = 1; sel = 0; in_valid = 4'hF; out_ready = 1;
        in_data = {w[3], w[2], w[1], w[0]};
        #1 rst_n = 0; #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (in_ready !== 4'h0) begin failures++; $display("FAIL reset_ready got=%b exp=0000", in_ready); end
        repeat (2) @(posedge clk); #1;
        checks++; if (in_ready !== 4'h0 || out_valid !== 1'b0) begin failures++; $display("FAIL reset_hold ready=%b valid=%b exp=0000/0", in_ready, out_valid); end
        rst_n = 1; #1;
        checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL reset_first_grant got=%b exp=0001", in_ready); end
        tick;
        checks++; if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== w[0]) begin failures++; $display("FAIL reset_first_out v=%b ch=%0d d=%h exp=1/0/%h", out_valid, out_chan, out_data, w[0]); end
    endtask

    task automatic test_fixed;
        mode = 0; sel = 2; in_valid = 4'hF; out_ready = 1; #1;
        checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL fixed_ready got=%b exp=0100", in_ready); end
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (out_data !== w[2] || out_chan !== 2'd2 || out_valid !== 1'b1) begin failures++; $display("FAIL fixed_out[%0d] d=%h ch=%0d v=%b exp=cccc/2/1", i, out_data, out_chan, out_valid); end
            checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL fixed_ready[%0d] got=%b exp=0100", i, in_ready); end
        end
    endtask

    task automatic test_round_robin;
        do_reset;
        mode = 1; in_valid = 4'hF; out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            tick;
            checks++; if (out_valid !== 1'b1 || out_chan !== 2'(i % 4) || out_data !== w[i % 4]) begin failures++; $display("FAIL rr_all[%0d] v=%b ch=%0d d=%h exp=1/%0d/%h", i, out_valid, out_chan, out_data, i % 4, w[i % 4]); end
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (out_valid !== 1'b1 || out_chan !== ((i % 2) ? 2'd3 : 2'd1)) begin failures++; $display("FAIL rr_odd[%0d] v=%b ch=%0d exp=1/%0d", i, out_valid, out_chan, (i % 2) ? 3 : 1); end
        end
    endtask

    task automatic test_backpressure;
        do_reset;
        mode = 1; in_valid = 4'hF; out_ready = 1;
        tick;
        out_ready = 0; #1;
        checks++; if (in_ready !== 4'h0) begin failures++; $display("FAIL bp_ready got=%b exp=0000", in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== w[0] || in_ready !== 4'h0) begin failures++; $display("FAIL bp_hold[%0d] v=%b ch=%0d d=%h rdy=%b exp=1/0/aaaa/0000", i, out_valid, out_chan, out_data, in_ready); end
        end
        out_ready = 1; #1;
        checks++; if (in_ready !== 4'b0010) begin failures++; $display("FAIL bp_resume_ready got=%b exp=0010", in_ready); end
        for (int i = 1; i < 3; i++) begin
            tick;
            checks++; if (out_chan !== 2'(i) || out_data !== w[i]) begin failures++; $display("FAIL bp_resume[%0d] ch=%0d d=%h exp=%0d/%h", i, out_chan, out_data, i, w[i]); end
        end
    endtask

    task automatic test_mode_switch;
        do_reset;
        mode = 1; in_valid = 4'hF; out_ready = 1;
        tick; tick;
        checks++; if (out_chan !== 2'd1) begin failures++; $display("FAIL ms_pre ch=%0d exp=1", out_chan); end
        mode = 0; sel = 3;
        for (int i = 0; i < 2; i++) begin
            tick;
            checks++; if (out_chan !== 2'd3 || out_data !== w[3]) begin failures++; $display("FAIL ms_fixed[%0d] ch=%0d d=%h exp=3/dddd", i, out_chan, out_data); end
        end
        mode = 1;
        tick;
        checks++; if (out_chan !== 2'd2 || out_data !== w[2]) begin failures++; $display("FAIL ms_resume ch=%0d d=%h exp=2/cccc", out_chan, out_data); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 500; i++) begin
            in_valid  = 4'($urandom);
            in_data   = {$urandom, $urandom};
            mode      = ($urandom_range(0, 3) != 0);
            sel       = 2'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            checks++; if (in_ready !== m_rdy) begin failures++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, in_ready, m_rdy); end
            tick;
            checks++; if (out_valid !== m_valid || out_chan !== m_chan || out_data !== m_data) begin failures++; $display("FAIL rand_out[%0d] v=%b ch=%0d d=%h exp=%b/%0d/%h", i, out_valid, out_chan, out_data, m_valid, m_chan, m_data); end
        end
    endtask

    task automatic test_non_pow2;
        in_valid = 0; out_ready = 1;
        mode3 = 0; sel3 = 3; in_valid3 = 3'b111; out_ready3 = 1;
        in_data3 = {16'h3333, 16'h2222, 16'h1111}; #1;
        checks++; if (in_ready3 !== 3'b000) begin failures++; $display("FAIL np2_ready got=%b exp=000", in_ready3); end
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (out_valid3 !== 1'b0 || in_ready3 !== 3'b000) begin failures++; $display("FAIL np2_idle[%0d] v=%b rdy=%b exp=0/000", i, out_valid3, in_ready3); end
        end
        sel3 = 1;
        tick;
        checks++; if (out_valid3 !== 1'b1 || out_chan3 !== 2'd1 || out_data3 !== 16'h2222) begin failures++; $display("FAIL np2_sel1 v=%b ch=%0d d=%h exp=1/1/2222", out_valid3, out_chan3, out_data3); end
        in_valid = 4'hF; mode = 1;
        tick;
        #2 rst_n = 0; #1;
        checks++; if (out_valid3 !== 1'b0 || out_valid !== 1'b0 || out_data3 !== 16'h0) begin failures++; $display("FAIL midreset v3=%b v=%b d3=%h exp=0/0/0", out_valid3, out_valid, out_data3); end
        rst_n = 1;
    endtask

    initial begin
        in_valid3 = 0; mode3 = 0; sel3 = 0; out_ready3 = 1; in_data3 = 0;
        test_reset;
        test_fixed;
        test_round_robin;
        test_backpressure;
        test_mode_switch;
        test_random;
        test_non_pow2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
